// File: rtl/fir_dp_pkg.sv
// fir_dp_pkg: shared constants for the parametrised FIR/CPU datapath.
//   - alu_op encodings (OP_ADD .. OP_NOP)
//   - default widths for DW, NREG and IMM_W
package fir_dp_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_MAC   = 3'd5;
  localparam logic [2:0] OP_ACCRD = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  localparam int DW_DEF    = 16;
  localparam int NREG_DEF  = 4;
  localparam int IMM_W_DEF = 8;

endpackage

// File: rtl/fir_datapath_p_seq_mul.sv
// seq_mul: DW x DW unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          latch a/b and begin (ignored while busy)
//   a, b           operands (DW)
//   busy           high from the start edge until the final step edge
//   last           high in the cycle whose rising edge performs the final step
//   done           one-cycle pulse after the final step
//   product        2DW running sum including the current step; the full
//                  product when last is high
module seq_mul #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            last,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW);

  logic [2*DW-1:0] mcand;
  logic [2*DW-1:0] psum;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  assign last    = busy && (cnt == '0);
  // The step sum is exposed so the owner can commit the result on the same
  // edge as the final step instead of one cycle later.
  assign product = psum + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      psum   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= last;
      if (start && !busy) begin
        busy   <= 1'b1;
        mcand  <= {{DW{1'b0}}, a};
        mplier <= b;
        psum   <= '0;
        cnt    <= CW'(DW - 1);
      end else if (busy) begin
        psum   <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (last) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_datapath_p.sv
// fir_datapath_p: parametrised FIR/CPU datapath (PC/address unit, register
// file, ALU with sequential multiplier, status flags, split data bus).
// Optional feature macro: FIR_DATAPATH_MAC_EN adds the 2DW accumulator used by
// MAC and ACCRD; without it MAC behaves as MUL and ACCRD as NOP.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   data_in / data_out / data_oe    bus read data, write data, drive enable
//   addr_out                        address register
//   reset_pc .. r_plus_0            addressing strobes (priority in that order)
//   ir_load, instruction            instruction register load / contents
//   rf_write, waddr, laddr, raddr   register file write and read selects
//   alu_op, alu_start, alu_busy, alu_done   ALU control handshake
//   addr_on_data, alu_on_data       data_out source selects
//   sr_load, cset, creset, zset, zreset, cout, zout   status register
module fir_datapath_p
  import fir_dp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int IMM_W = IMM_W_DEF,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic [DW-1:0] addr_out,
  input  logic          reset_pc,
  input  logic          pc_plus_i,
  input  logic          pc_plus_1,
  input  logic          r_plus_i,
  input  logic          r_plus_0,
  input  logic          ir_load,
  input  logic          rf_write,
  input  logic [RW-1:0] waddr,
  input  logic [RW-1:0] laddr,
  input  logic [RW-1:0] raddr,
  input  logic [2:0]    alu_op,
  input  logic          alu_start,
  output logic          alu_busy,
  output logic          alu_done,
  input  logic          addr_on_data,
  input  logic          alu_on_data,
  input  logic          sr_load,
  input  logic          cset,
  input  logic          creset,
  input  logic          zset,
  input  logic          zreset,
  output logic [DW-1:0] instruction,
  output logic          cout,
  output logic          zout
);

  logic [DW-1:0]   pc, pc_nxt, addr_nxt, ir, imm, l_op, r_op;
  logic [DW-1:0]   rf [NREG];
  logic [DW-1:0]   result, res_nxt;
  logic            alu_c, alu_z, c_nxt, z_nxt;
  logic            start_ok, is_mul_op, single_done;
  logic            mul_busy, mul_last, mul_done;
  logic [2*DW-1:0] product;
`ifdef FIR_DATAPATH_MAC_EN
  logic [2*DW-1:0] acc, acc_nxt;
  logic            mac_pend;
`endif

  assign imm  = {{(DW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign l_op = rf[laddr];
  assign r_op = rf[raddr];

  always_comb begin
    pc_nxt   = pc;
    addr_nxt = addr_out;
    if (reset_pc) begin
      pc_nxt   = '0;
      addr_nxt = '0;
    end else if (pc_plus_i) begin
      pc_nxt   = pc + imm;
      addr_nxt = pc_nxt;
    end else if (pc_plus_1) begin
      pc_nxt   = pc + 1'b1;
      addr_nxt = pc_nxt;
    end else if (r_plus_i) begin
      addr_nxt = r_op + imm;
    end else if (r_plus_0) begin
      addr_nxt = r_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      addr_out <= '0;
      ir       <= '0;
    end else begin
      pc       <= pc_nxt;
      addr_out <= addr_nxt;
      if (ir_load) ir <= data_in;
    end
  end

  assign instruction = ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (rf_write) begin
      rf[waddr] <= data_in;
    end
  end

  assign is_mul_op = (alu_op == OP_MUL) || (alu_op == OP_MAC);
  assign start_ok  = alu_start && !mul_busy;

  seq_mul #(.DW(DW)) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_ok && is_mul_op),
    .a       (l_op),
    .b       (r_op),
    .busy    (mul_busy),
    .last    (mul_last),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    res_nxt = result;
    c_nxt   = alu_c;
    z_nxt   = alu_z;
`ifdef FIR_DATAPATH_MAC_EN
    acc_nxt = acc;
`endif
    if (mul_last) begin
      res_nxt = product[DW-1:0];
      c_nxt   = |product[2*DW-1:DW];
`ifdef FIR_DATAPATH_MAC_EN
      if (mac_pend) begin
        {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, product};
        res_nxt          = acc_nxt[DW-1:0];
      end
`endif
      z_nxt = (res_nxt == '0);
    end else if (start_ok && !is_mul_op) begin
      case (alu_op)
        OP_ADD: {c_nxt, res_nxt} = {1'b0, l_op} + {1'b0, r_op};
        // The extra top bit of a widened subtract is the borrow.
        OP_SUB: {c_nxt, res_nxt} = {1'b0, l_op} - {1'b0, r_op};
        OP_AND: res_nxt = l_op & r_op;
        OP_OR:  res_nxt = l_op | r_op;
`ifdef FIR_DATAPATH_MAC_EN
        OP_ACCRD: res_nxt = acc[DW-1:0];
`endif
        default: ;
      endcase
`ifdef FIR_DATAPATH_MAC_EN
      if (alu_op != OP_NOP) z_nxt = (res_nxt == '0);
`else
      if (alu_op != OP_NOP && alu_op != OP_ACCRD) z_nxt = (res_nxt == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      alu_c       <= 1'b0;
      alu_z       <= 1'b0;
      single_done <= 1'b0;
    end else begin
      result      <= res_nxt;
      alu_c       <= c_nxt;
      alu_z       <= z_nxt;
      single_done <= start_ok && !is_mul_op;
    end
  end

`ifdef FIR_DATAPATH_MAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mac_pend <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (start_ok && is_mul_op) mac_pend <= (alu_op == OP_MAC);
    end
  end
`endif

  assign alu_busy = mul_busy;
  assign alu_done = single_done || mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout <= 1'b0;
      zout <= 1'b0;
    end else begin
      if (creset)       cout <= 1'b0;
      else if (cset)    cout <= 1'b1;
      else if (sr_load) cout <= alu_c;
      if (zreset)       zout <= 1'b0;
      else if (zset)    zout <= 1'b1;
      else if (sr_load) zout <= alu_z;
    end
  end

  always_comb begin
    data_out = '0;
    if (addr_on_data)     data_out = addr_out;
    else if (alu_on_data) data_out = result;
  end

  assign data_oe = addr_on_data || alu_on_data;

endmodule

// File: tb/tb_fir_datapath_p.sv
// Directed bench for fir_datapath_p (DW=16, NREG=4, IMM_W=8). ALU expectations
// are queued when an op is started and popped when alu_done is seen.
module tb_fir_datapath_p;
  import fir_dp_pkg::*;

  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] res;
    logic          c;
    logic          z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in, data_out, addr_out, instruction;
  logic          data_oe, reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0;
  logic          ir_load, rf_write, alu_start, alu_busy, alu_done;
  logic [1:0]    waddr, laddr, raddr;
  logic [2:0]    alu_op;
  logic          addr_on_data, alu_on_data, sr_load, cset, creset, zset, zreset;
  logic          cout, zout;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fir_datapath_p dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .addr_out(addr_out), .reset_pc(reset_pc),
    .pc_plus_i(pc_plus_i), .pc_plus_1(pc_plus_1), .r_plus_i(r_plus_i),
    .r_plus_0(r_plus_0), .ir_load(ir_load), .rf_write(rf_write),
    .waddr(waddr), .laddr(laddr), .raddr(raddr), .alu_op(alu_op),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
    .addr_on_data(addr_on_data), .alu_on_data(alu_on_data),
    .sr_load(sr_load), .cset(cset), .creset(creset), .zset(zset),
    .zreset(zreset), .instruction(instruction), .cout(cout), .zout(zout)
  );

  function automatic exp_t mk(input logic [DW-1:0] r, input logic c, input logic z);
    exp_t e;
    e.res = r; e.c = c; e.z = z;
    return e;
  endfunction

  function automatic exp_t mul_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return mk(p[DW-1:0], |p[2*DW-1:DW], p[DW-1:0] == '0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] val);
    rf_write = 1'b1; waddr = idx[1:0]; data_in = val;
    tick();
    rf_write = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input int l, input int r, input exp_t e);
    alu_op = op; laddr = l[1:0]; raddr = r[1:0]; alu_start = 1'b1;
    sb.push_back(e);
    tick();
    alu_start = 1'b0; alu_op = OP_NOP;
  endtask

  // Waits (bounded) for alu_done; lat counts edges after the start edge.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (alu_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_tests++;
    assert (sb.size() > 0)
    else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_res"}, data_out, e.res);
      sr_load = 1'b1;
      tick();
      sr_load = 1'b0;
      chk({tag, "_c"}, cout, e.c);
      chk({tag, "_z"}, zout, e.z);
      chk({tag, "_donepulse"}, alu_done, 1'b0);
    end
  endtask

  task automatic finish_op(input string tag, input int exp_lat);
    wait_done(tag, 0, exp_lat);
    check_out(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    exp_t e;
    rst_n = 1'b0; data_in = '0; reset_pc = 0; pc_plus_i = 0; pc_plus_1 = 0;
    r_plus_i = 0; r_plus_0 = 0; ir_load = 0; rf_write = 0; waddr = 0; laddr = 0;
    raddr = 0; alu_op = OP_NOP; alu_start = 0; addr_on_data = 0; alu_on_data = 0;
    sr_load = 0; cset = 0; creset = 0; zset = 0; zreset = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_addr", addr_out, 0);
    chk("rst_z", zout, 0);
    chk("rst_c", cout, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ir", instruction, 0);
    chk("rst_busy", alu_busy, 0);
    chk("rst_done", alu_done, 0);

    pc_plus_1 = 1; tick(); tick(); tick(); pc_plus_1 = 0;
    chk("pc1x3", addr_out, 3);
    tick();
    chk("hold", addr_out, 3);

    data_in = 16'h00FE; ir_load = 1; tick(); ir_load = 0;
    chk("ir_load", instruction, 16'h00FE);

    reset_pc = 1; pc_plus_1 = 1; tick(); reset_pc = 0;
    chk("prio_reset", addr_out, 0);
    tick(); tick(); pc_plus_1 = 0;
    chk("pc_eq2", addr_out, 2);
    pc_plus_i = 1; pc_plus_1 = 1; tick(); pc_plus_i = 0; pc_plus_1 = 0;
    chk("pc_plus_i", addr_out, 0);
    pc_plus_1 = 1; tick(); pc_plus_1 = 0;
    chk("pc_after_i", addr_out, 1);
    wr(1, 16'h0010);
    raddr = 1; r_plus_i = 1; tick(); r_plus_i = 0;
    chk("r_plus_i", addr_out, 16'h000E);
    r_plus_0 = 1; tick(); r_plus_0 = 0;
    chk("r_plus_0", addr_out, 16'h0010);
    pc_plus_1 = 1; tick(); pc_plus_1 = 0;
    chk("pc_kept", addr_out, 2);
    addr_on_data = 1; alu_on_data = 1; #1;
    chk("dout_addr", data_out, 2);
    chk("oe_addr", data_oe, 1);
    addr_on_data = 0; #1;
    chk("dout_alu", data_out, 0);

    // ADD with a same-cycle write of R1: the old R1 (1) must be used.
    wr(0, 16'hFFFF); wr(1, 16'h0001);
    rf_write = 1; waddr = 1; data_in = 16'h0005;
    start_op(OP_ADD, 0, 1, mk(16'h0000, 1, 1));
    rf_write = 0;
    chk("add_busy", alu_busy, 0);
    finish_op("add", 0);
    start_op(OP_SUB, 1, 0, mk(16'h0006, 1, 0));
    finish_op("sub", 0);
    wr(2, 16'h0F0F); wr(3, 16'hF0F5);
    start_op(OP_AND, 2, 3, mk(16'h0005, 1, 0));
    finish_op("and", 0);
    start_op(OP_SUB, 3, 3, mk(16'h0000, 0, 1));
    finish_op("sub_eq", 0);
    start_op(OP_OR, 2, 3, mk(16'hFFFF, 0, 0));
    finish_op("or", 0);
    start_op(OP_NOP, 0, 1, mk(16'hFFFF, 0, 0));
    finish_op("nop", 0);

    cset = 1; sr_load = 1; tick(); cset = 0; sr_load = 0;
    chk("cset_over_load", cout, 1);
    chk("z_load", zout, 0);
    cset = 1; creset = 1; zset = 1; zreset = 1; tick();
    cset = 0; creset = 0; zreset = 0;
    chk("creset_prio", cout, 0);
    chk("zreset_prio", zout, 0);
    tick(); zset = 0;
    chk("zset", zout, 1);

    // MUL with an ignored start and an operand rewrite mid-operation.
    wr(2, 16'h0100); wr(3, 16'h0100);
    start_op(OP_MUL, 2, 3, mul_model(16'h0100, 16'h0100));
    tick(); tick(); tick(); tick();
    chk("mul_busy", alu_busy, 1);
    alu_op = OP_ADD; laddr = 0; raddr = 1; alu_start = 1; tick();
    alu_start = 0; alu_op = OP_NOP;
    wr(2, 16'h1234);
    wait_done("mul", 6, 16);
    check_out("mul");

    // Back-to-back: second start in the alu_done cycle of the first.
    wr(3, 16'h0003);
    start_op(OP_MUL, 2, 3, mul_model(16'h1234, 16'h0003));
    wait_done("mul_a", 0, 16);
    e = sb.pop_front();
    chk("mul_a_res", data_out, e.res);
    start_op(OP_MUL, 0, 0, mul_model(16'hFFFF, 16'hFFFF));
    finish_op("mul_b", 16);

`ifdef FIR_DATAPATH_MAC_EN
    wr(0, 16'd3); wr(1, 16'd4); wr(2, 16'd5); wr(3, 16'd6);
    start_op(OP_MAC, 0, 1, mk(16'd12, 0, 0));
    finish_op("mac1", 16);
    start_op(OP_MAC, 2, 3, mk(16'd42, 0, 0));
    finish_op("mac2", 16);
    start_op(OP_ADD, 0, 1, mk(16'd7, 0, 0));
    finish_op("add7", 0);
    start_op(OP_ACCRD, 0, 0, mk(16'd42, 0, 0));
    finish_op("accrd", 0);
`else
    wr(1, 16'hFFFF);
    start_op(OP_MAC, 0, 1, mk(16'h0001, 1, 0));
    finish_op("mac_as_mul", 16);
    start_op(OP_ACCRD, 0, 0, mk(16'h0001, 1, 0));
    finish_op("accrd_nop", 0);
`endif

    // Reset at cycle 8 of a multiply.
    wr(2, 16'h0100); wr(3, 16'h0100);
    start_op(OP_MUL, 2, 3, mul_model(16'h0100, 16'h0100));
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0; #1;
    chk("rstmul_busy", alu_busy, 0);
    chk("rstmul_done", alu_done, 0);
    chk("rstmul_res", data_out, 0);
    chk("rstmul_c", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (alu_done === 1'b1) ndone++;
    end
    chk("rstmul_nodone", ndone, 0);
    chk("rstmul_res2", data_out, 0);
    chk("rstmul_busy2", alu_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_datapath_p.md
# fir_datapath_p

Parametrised successor to the team's fixed 16-bit FIR/CPU datapath. It adds a configurable data width and register-file depth, a sequential shift-add multiplier with a start/busy/done handshake, an optional multiply-accumulate unit, and a split data bus instead of a tri-state bus. It sits between the controller FSM and the memory/bus interface, and all control strobes are driven by the controller.

## Interface
Parameters:
- DW, 16: data, address and PC width (≥8).
- NREG, 4: register-file entries (power of 2, ≥2); RW = log2(NREG).
- IMM_W, 8: width of the immediate field at instruction[IMM_W-1:0] (< DW).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DW  bus read data (memory, or loop-back of data_out).
- data_out  out  DW  bus write data.
- data_oe  out  1  data_out valid/drive enable.
- addr_out  out  DW  address register.
- reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0  in  1 each  addressing-mode strobes.
- ir_load  in  1  load instruction register from data_in.
- rf_write  in  1  write data_in to R[waddr].
- waddr, laddr, raddr  in  RW each  register-file write, left-operand and right-operand selects.
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 MAC, 6 ACCRD, 7 NOP.
- alu_start  in  1  start the ALU operation.
- alu_busy  out  1  multi-cycle operation in progress.
- alu_done  out  1  one-cycle result pulse.
- addr_on_data, alu_on_data  in  1 each  data_out source selects.
- sr_load, cset, creset, zset, zreset  in  1 each  status-register controls.
- instruction  out  DW  IR contents.
- cout, zout  out  1 each  status flags.

## Operation
- Reset values: PC, addr_out, IR, every R[i], ALU result register, accumulator, cout, zout, alu_busy, alu_done all 0. With no source selected, data_out = 0 and data_oe = 0.
- Addressing: the strobes are resolved by priority reset_pc > pc_plus_i > pc_plus_1 > r_plus_i > r_plus_0. imm = sign-extended instruction[IMM_W-1:0].
  - reset_pc: PC←0, addr←0.
  - pc_plus_i: PC←PC+imm, addr←new PC.
  - pc_plus_1: PC←PC+1, addr←new PC.
  - r_plus_i: addr←R[raddr]+imm; PC unchanged.
  - r_plus_0: addr←R[raddr]; PC unchanged.
  - All sums wrap modulo 2^DW. With no strobe, PC and addr hold.
- Register file: rf_write writes data_in to R[waddr]. Reads are combinational; L = R[laddr], R = R[raddr].
- ALU: alu_start is accepted only when alu_busy = 0; a start while busy is ignored.
  - ADD/SUB/AND/OR/NOP/ACCRD: result register written on the start edge.
    - ADD: C = carry out. SUB: C = borrow.
    - Logic ops and NOP: C unchanged. NOP: result unchanged.
    - ACCRD: result←acc[DW-1:0].
  - MUL: operands are latched at the start edge; unsigned shift-add, one bit per cycle. result = low DW bits of the product; C = |product[2DW-1:DW].
  - MAC: same as MUL, then acc←acc+product (2DW bits, wraps). result = new acc[DW-1:0]; C = carry out of the acc add.
  - Z = (result == 0) for every op except NOP.
- Status register, per flag: reset > set > sr_load (sr_load captures the ALU C/Z at the alu_done cycle) > hold. The C and Z flags are controlled independently.
- Data output: addr_on_data takes priority (addr_out), otherwise alu_on_data (result register). data_oe = addr_on_data | alu_on_data.
- IR: ir_load sets IR←data_in.

## Timing
- Single-cycle ops: start at edge E0 gives result valid after E0; alu_done high for the cycle after E0; alu_busy stays 0.
- MUL/MAC: alu_busy is high from E0 until edge E_DW; result and acc update at E_DW; alu_done is high for the cycle after E_DW. Latency is DW cycles, and a new start is accepted the cycle alu_done is high.
- Register operands change during MUL without effect, because they are latched at E0.
- rf_write and a read of the same index in one cycle: the read returns the old value.
- rst_n low mid-multiply clears everything asynchronously; no alu_done is produced.

## Configuration
- FIR_DATAPATH_MAC_EN defined: the 2DW accumulator exists, and MAC and ACCRD behave as above.
- Not defined: no accumulator. MAC behaves exactly as MUL, and ACCRD behaves as NOP (single-cycle, Z/C unchanged).

## Structure
- Package fir_dp_pkg holds:
  - the alu_op encodings as localparams (OP_ADD … OP_NOP);
  - default widths.
- Sub-module seq_mul (DW×DW unsigned shift-add with start/busy/done and a 2DW product) is instantiated once. The accumulator stays in the top module.

## Test plan
- Reset then idle: addr_out = 0, zout = 0, data_oe = 0. Then pc_plus_1 ×3 gives addr_out = 3.
- IR = 16'h00FE, pc_plus_i from PC = 2 gives PC = 0; r_plus_i with R1 = 16'h0010 gives addr = 16'h000E.
- R0 = 16'hFFFF, R1 = 1, ADD then sr_load gives result 0, C = 1, Z = 1; alu_done after one cycle.
- MUL 16'h0100×16'h0100 (DW = 16): busy for 16 cycles, result 0, C = 1, Z = 1; a start issued mid-operation is ignored.
- With MAC_EN: MAC 3×4, MAC 5×6, ACCRD gives result 42. Without MAC_EN: ACCRD leaves result unchanged.
- rst_n pulsed at cycle 8 of a MUL: busy = 0, no alu_done, result = 0.
